stats_sequencer: RTL
====================

// Module: stats_sequencer
// PURPOSE
//  Run controller for the TRNG statistics unit. Accepts a "collect N samples" command and pulses GO to clear the histogram.
//  Gates the raw 16-bit sample stream into the unit, then sweeps STAT_ADDR 0..NUM_BINS-1.
//  Each statistic word is streamed out on a valid/ready port (word 0 = runs count, words 1.. = bin frequencies).
//  Sits between the TRNG sample source / AXI register block and the statistics unit.
// PARAMETERS
//  CNT_W      32  width of sample count (CMD_COUNT)
//  ADDR_W      8  stats address width; NUM_BINS = 2**ADDR_W
//  DRAIN_CYC   2  idle cycles after last sample before first read (covers unit's 2-stage write pipe)
//  TMO_W      20  timeout counter width (used only with STATS_TIMEOUT_EN)
// PORTS
//  CLK        in   1      clock
//  RST        in   1      synchronous, active-high reset
//  CMD_START  in   1      start request; accepted only in IDLE
//  CMD_COUNT  in   CNT_W  samples to collect, sampled on accepted CMD_START
//  CMD_ABORT  in   1      abort run; return to IDLE
//  BUSY       out  1      high in every state except IDLE
//  DONE       out  1      1-cycle pulse after last word handshaked
//  ERR        out  1      sticky timeout flag; cleared on next accepted CMD_START
//  SRC_DATA   in   16     raw TRNG sample
//  SRC_VALID  in   1      sample valid
//  SRC_READY  out  1      = (state==COLLECT)
//  ST_GO      out  1      clear pulse to stats unit
//  ST_STOP    out  1      run-finished level to stats unit
//  ST_DATA    out  16     = SRC_DATA (combinational)
//  ST_RE      out  1      = SRC_VALID & SRC_READY (combinational)
//  ST_ADDR    out  ADDR_W stats read address (registered)
//  ST_STATS   in   32     stats word; valid 1 cycle after ST_ADDR changes
//  OUT_DATA   out  32     captured statistic
//  OUT_LAST   out  1      high with word NUM_BINS-1
//  OUT_VALID  out  1      output word valid
//  OUT_READY  in   1      consumer ready
// BEHAVIOUR
//  Reset: state=IDLE. BUSY, DONE, ERR, ST_GO, ST_STOP, OUT_VALID and OUT_LAST = 0; ST_ADDR, OUT_DATA and counters = 0.
//  FSM: IDLE -> CLEAR -> COLLECT -> DRAIN -> RD_SET -> RD_CAP -> OUT -> (RD_SET | FIN) -> IDLE
//  IDLE:   CMD_START -> latch CMD_COUNT into remaining counter; go to CLEAR. CMD_START ignored in every other state.
//  CLEAR:  ST_GO=1 for exactly 1 cycle; next COLLECT, or DRAIN directly if count==0.
//  COLLECT: each SRC_VALID cycle is one sample; remaining--. On the cycle remaining goes 1->0, go to DRAIN. No backpressure is applied mid-run.
//  DRAIN:  ST_STOP=1 from here until IDLE. Wait DRAIN_CYC cycles, ST_ADDR=0, then go to RD_SET.
//  RD_SET: 1 cycle; ST_ADDR stable so the unit's registered read settles.
//  RD_CAP: OUT_DATA<=ST_STATS; OUT_VALID<=1; OUT_LAST<=(ST_ADDR==NUM_BINS-1).
//  OUT:    hold OUT_DATA, OUT_LAST and OUT_VALID until OUT_READY.
//          On handshake: OUT_VALID<=0. If last, go to FIN; else ST_ADDR++ and go to RD_SET.
//          Throughput: 1 word / 3 cycles.
//  FIN:    DONE=1 for 1 cycle, ST_STOP<=0, then IDLE.
//  Counter: CNT_W bits; count up to 2**CNT_W-1 accepted. ST_ADDR never wraps (LAST terminates the sweep).
//  CMD_ABORT (highest priority below RST), any non-IDLE state: next cycle IDLE.
//    OUT_VALID, OUT_LAST, ST_STOP and ST_GO = 0; no DONE; ERR unchanged.
//    CMD_START in the same cycle as CMD_ABORT is ignored.
//  RST mid-run: identical to power-on reset. The stats unit's contents are don't-care until the next GO.
// CONFIGURATION
//  STATS_TIMEOUT_EN defined: in COLLECT a TMO_W-bit counter increments on each cycle without SRC_VALID and clears on a sample.
//    At all-ones: ERR<=1, remaining is discarded, go to DRAIN. The partial histogram is still swept out and DONE still pulses.
//  STATS_TIMEOUT_EN undefined: no timeout counter; ERR tied 0; COLLECT waits indefinitely.
// STRUCTURE
//  Package stats_pkg: state enum typedef, STATS_ADDR_W=8, STATS_WORD_W=32, STATS_RUNS_ADDR='0.
//  Single module, no sub-module. The FSM, sample counter, address counter and output register are all local.
// TESTING
//  1) COUNT=16, SRC_DATA=i&0xFF for i=0..15, VALID every cycle.
//     -> ST_GO 1 cycle. Word1..15=1, word0=run count, words16..255=0. LAST on word 255 only; DONE once.
//  2) COUNT=4, samples 0x0005 x4 back-to-back -> word5=4 (same-address pipeline merge correct); ST_RE exactly 4 cycles.
//  3) COUNT=0 -> no ST_RE; 256 words, all bins except word0 = 0; DONE pulses.
//  4) OUT_READY toggling randomly with a 10-cycle stall on word 100 -> OUT_DATA/OUT_LAST stable while VALID & !READY; 256 words total.
//  5) CMD_ABORT during COLLECT, then during OUT -> IDLE next cycle; OUT_VALID=0; no DONE; a new CMD_START runs cleanly.
//  6) [STATS_TIMEOUT_EN, TMO_W=4] COUNT=10, only 3 samples sent -> after 15 idle cycles ERR=1; sweep completes; ERR clears on next start.

Source files
------------

// File: rtl/stats_pkg.sv
// Shared constants and FSM state type for the TRNG statistics run controller.
package stats_pkg;

  localparam int unsigned STATS_ADDR_W = 8;
  localparam int unsigned STATS_WORD_W = 32;
  localparam int unsigned SAMPLE_W     = 16;

  // Word 0 of every sweep is the runs count kept by the statistics unit.
  localparam logic [STATS_ADDR_W-1:0] STATS_RUNS_ADDR = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COLLECT,
    S_DRAIN,
    S_RD_SET,
    S_RD_CAP,
    S_OUT,
    S_FIN
  } state_t;

  // ST_STOP is held from the start of the drain until the run finishes.
  function automatic logic stop_window(input state_t s);
    return (s == S_DRAIN) || (s == S_RD_SET) || (s == S_RD_CAP) ||
           (s == S_OUT)   || (s == S_FIN);
  endfunction

endpackage

// File: rtl/stats_sequencer.sv
// Run controller for the TRNG statistics unit: clears the histogram, gates a
// fixed number of raw samples into it, then sweeps every statistic word out on
// a valid/ready port. Optional feature macro: STATS_TIMEOUT_EN (sample-stream
// timeout that sets the sticky ERR flag and cuts the collection short).
module stats_sequencer
  import stats_pkg::*;
#(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned ADDR_W    = STATS_ADDR_W,
  parameter int unsigned DRAIN_CYC = 2
`ifdef STATS_TIMEOUT_EN
  ,
  parameter int unsigned TMO_W     = 20
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_start,
  input  logic [CNT_W-1:0]        cmd_count,
  input  logic                    cmd_abort,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [SAMPLE_W-1:0]     src_data,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic                    st_go,
  output logic                    st_stop,
  output logic [SAMPLE_W-1:0]     st_data,
  output logic                    st_re,
  output logic [ADDR_W-1:0]       st_addr,
  input  logic [STATS_WORD_W-1:0] st_stats,
  output logic [STATS_WORD_W-1:0] out_data,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    DRAIN_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   remaining_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               start_accept;
  logic               abort_run;
  logic               timeout_hit;
  logic               last_sample;

  // A start is only honoured from IDLE and never alongside an abort.
  assign start_accept = (state_q == S_IDLE) && cmd_start && !cmd_abort;
  assign abort_run    = (state_q != S_IDLE) && cmd_abort;
  assign last_sample  = src_valid && (remaining_q == CNT_W'(1));

  // Raw samples pass straight through; the unit only sees them while collecting.
  assign st_data = src_data;
  assign st_re   = src_valid && src_ready;

`ifdef STATS_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q;

  // Fire on the idle cycle that would carry the counter to all-ones.
  assign timeout_hit = (state_q == S_COLLECT) && !src_valid &&
                       (tmo_q == {{(TMO_W-1){1'b1}}, 1'b0});

  // Idle-cycle counter: restarts on every sample and outside COLLECT.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else if ((state_q != S_COLLECT) || src_valid) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  // Sticky error flag: set by a timeout, cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start_accept) begin
      err <= 1'b0;
    end else if (timeout_hit && !cmd_abort) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded control outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves it unassigned and infers a latch.
    state_d   = state_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
    st_go     = (state_q == S_CLEAR);
    st_stop   = stop_window(state_q);
    src_ready = (state_q == S_COLLECT);

    unique case (state_q)
      S_IDLE:    if (start_accept) state_d = S_CLEAR;
      S_CLEAR:   state_d = (remaining_q == '0) ? S_DRAIN : S_COLLECT;
      S_COLLECT: if (last_sample || timeout_hit) state_d = S_DRAIN;
      S_DRAIN:   if (drain_q == DRAIN_LAST) state_d = S_RD_SET;
      S_RD_SET:  state_d = S_RD_CAP;
      S_RD_CAP:  state_d = S_OUT;
      S_OUT:     if (out_ready) state_d = out_last ? S_FIN : S_RD_SET;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (abort_run) state_d = S_IDLE;
  end

  // Sample counter, drain timer, read address and output word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      drain_q     <= '0;
      st_addr     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else if (abort_run) begin
      drain_q   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_accept) remaining_q <= cmd_count;
        end
        S_COLLECT: begin
          if (src_valid) begin
            remaining_q <= remaining_q - 1'b1;
          end else if (timeout_hit) begin
            remaining_q <= '0;
          end
        end
        S_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            drain_q <= '0;
            st_addr <= ADDR_W'(STATS_RUNS_ADDR);
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        S_RD_CAP: begin
          out_data  <= st_stats;
          out_valid <= 1'b1;
          out_last  <= (st_addr == '1);
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            // The address stops at the last bin; the sweep ends there.
            if (!out_last) st_addr <= st_addr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
